output_mux_ctrl: RTL and testbench
==================================

Name: output_mux_ctrl

Overview:
Sequencer for the per-bit output multiplexer that selects, per line, between the passthrough path and the injection path. It accepts switch requests (select mask plus hold time) over a valid/ready handshake and applies them only inside a quiet window on the monitored bus, so lines are never switched mid-transition. After the hold time, or on abort, it reverts to the default mask in the same glitch-safe way. It drives the mux select input directly.

Parameters:
WIDTH, 4, number of mux lines / select bits
IDLE_CYCLES, 8, consecutive unchanged bus samples required before any select change (>=1)
HOLD_WIDTH, 16, width of hold-time counter
DEFAULT_SEL, 0, select mask applied at reset and after revert (WIDTH bits)

Ports:
sys_clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
bus_line  input  WIDTH  monitored bus lines, already synchronized to sys_clk
req_sel  input  WIDTH  requested select mask
req_hold  input  HOLD_WIDTH  cycles to keep mask applied; 0 = persistent until abort
req_valid  input  1  request valid
req_ready  output  1  controller can accept request
abort  input  1  single-cycle pulse: cancel pending/active request
select_line  output  WIDTH  mux select, 1 = injection path for that bit
switch_pulse  output  1  one-cycle pulse on every select_line update
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, n_reset=0): state=IDLE, select_line=DEFAULT_SEL, switch_pulse=0, busy=0, req_ready=1 after release; prev_bus=0, quiet_cnt=0, hold_cnt=0, latched regs=0.
- All outputs registered except req_ready (= state==IDLE) and busy (= state!=IDLE).
- Bus-change detect: chg = (bus_line != prev_bus); prev_bus <= bus_line every cycle in all states.
- quiet_cnt width clog2(IDLE_CYCLES+1); cleared on chg and on every state entry; otherwise increments, saturating at IDLE_CYCLES-1.
- States:
  IDLE: on req_valid && req_ready latch req_sel, req_hold; -> WAIT_APPLY, quiet_cnt<=0.
  WAIT_APPLY: if abort -> IDLE, select_line unchanged, no pulse. Else if !chg && quiet_cnt==IDLE_CYCLES-1: select_line<=latched sel, switch_pulse<=1, hold_cnt<=latched hold -> ACTIVE.
  ACTIVE: abort -> WAIT_REVERT. Else if hold!=0: hold_cnt decrements each cycle; at hold_cnt==1 -> WAIT_REVERT. hold==0: stay until abort.
  WAIT_REVERT: same quiet rule as WAIT_APPLY; on completion select_line<=DEFAULT_SEL, switch_pulse<=1 -> IDLE. Abort ignored.
- Latency, quiet bus: select_line changes IDLE_CYCLES edges after acceptance edge. The mask stays applied for exactly hold cycles in ACTIVE plus the revert quiet window (>= IDLE_CYCLES).
- Continuous bus activity stalls WAIT_APPLY/WAIT_REVERT indefinitely; abort is the only exit from WAIT_APPLY.
- req_valid outside IDLE: not accepted (req_ready=0); requester holds it.
- Abort and request in the same IDLE cycle: request accepted; abort ignored.
- switch_pulse fires on each apply/revert even when the new mask equals the old mask.
- Mid-operation reset: immediate return to DEFAULT_SEL, all counters cleared, request dropped.

Decomposition:
- Shared package: state encoding (IDLE, WAIT_APPLY, ACTIVE, WAIT_REVERT), clog2 helper for quiet_cnt width.
- One sub-module: bus_quiet_detect (prev_bus register, change detect, quiet counter with clear input, quiet_done output), reused for both wait states.

Test Plan:
- Quiet bus, IDLE_CYCLES=8, req_sel=4'b1010, req_hold=5 -> select_line=1010 with switch_pulse exactly 8 edges after acceptance; back to 0000 after 5 + 8 cycles; two pulses total.
- Toggle bus_line[0] every 3 cycles for 30 cycles during WAIT_APPLY -> select_line stays 0000; applies 8 cycles after the last toggle.
- req_hold=0, req_sel=4'b1111 -> select stays 1111 for 200 cycles; abort -> 0000 after 8 quiet cycles, busy drops the same edge.
- Abort 3 cycles into WAIT_APPLY -> IDLE next edge, select_line never leaves 0000, no switch_pulse, req_ready=1.
- Second req_valid held during ACTIVE -> req_ready=0, not accepted; accepted the cycle after return to IDLE.
- Assert n_reset low during ACTIVE with select=0110 -> select_line=0000 asynchronously, busy=0; normal operation after release.

Source files
------------

// File: rtl/output_mux_ctrl_pkg.sv
// Shared types for the output mux sequencer: FSM state encoding and a
// constant-width helper for the quiet-window counter.
package output_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_APPLY  = 2'd1,
    ACTIVE      = 2'd2,
    WAIT_REVERT = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/output_mux_ctrl_bus_quiet_detect.sv
// Watches the bus for a run of unchanged samples; quiet_done is high when the
// current sample completes a window of IDLE_CYCLES unchanged samples.
module output_mux_ctrl_bus_quiet_detect
  import output_mux_ctrl_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_line,
  input  logic             clear,
  output logic             quiet_done
);

  localparam int            CW   = clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);

  logic [WIDTH-1:0] prev_bus;
  logic [CW-1:0]    quiet_cnt;
  logic             chg;

  assign chg        = (bus_line != prev_bus);
  assign quiet_done = !chg && (quiet_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bus  <= '0;
      quiet_cnt <= '0;
    end else begin
      prev_bus <= bus_line;
      if (clear || chg)
        quiet_cnt <= '0;
      else if (quiet_cnt != LAST)
        quiet_cnt <= quiet_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/output_mux_ctrl.sv
// Output mux sequencer: accepts select-mask requests and applies/reverts them
// only inside a quiet bus window so no line is switched mid-transition.
module output_mux_ctrl
  import output_mux_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               IDLE_CYCLES = 8,
  parameter int               HOLD_WIDTH  = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEL = '0
) (
  input  logic                  sys_clk,
  input  logic                  n_reset,
  input  logic [WIDTH-1:0]      bus_line,
  input  logic [WIDTH-1:0]      req_sel,
  input  logic [HOLD_WIDTH-1:0] req_hold,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  abort,
  output logic [WIDTH-1:0]      select_line,
  output logic                  switch_pulse,
  output logic                  busy
);

  state_t                state;
  logic [WIDTH-1:0]      sel_lat;
  logic [HOLD_WIDTH-1:0] hold_lat;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic                  quiet_done;
  logic                  state_exit;
  logic                  hold_last;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign hold_last = (hold_lat != '0) && (hold_cnt == HOLD_WIDTH'(1));

  // The quiet window restarts whenever the FSM leaves its current state.
  always_comb begin
    state_exit = 1'b0;
    case (state)
      IDLE:        state_exit = req_valid;
      WAIT_APPLY:  state_exit = abort || quiet_done;
      ACTIVE:      state_exit = abort || hold_last;
      WAIT_REVERT: state_exit = quiet_done;
      default:     state_exit = 1'b1;
    endcase
  end

  output_mux_ctrl_bus_quiet_detect #(
    .WIDTH       (WIDTH),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_quiet (
    .clk        (sys_clk),
    .rst_n      (n_reset),
    .bus_line   (bus_line),
    .clear      (state_exit),
    .quiet_done (quiet_done)
  );

  always_ff @(posedge sys_clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      select_line  <= DEFAULT_SEL;
      switch_pulse <= 1'b0;
      sel_lat      <= '0;
      hold_lat     <= '0;
      hold_cnt     <= '0;
    end else begin
      switch_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel_lat  <= req_sel;
            hold_lat <= req_hold;
            state    <= WAIT_APPLY;
          end
        end
        WAIT_APPLY: begin
          if (abort) begin
            state <= IDLE;
          end else if (quiet_done) begin
            select_line  <= sel_lat;
            switch_pulse <= 1'b1;
            hold_cnt     <= hold_lat;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A zero hold keeps the mask until an abort arrives.
          if (abort) begin
            state <= WAIT_REVERT;
          end else if (hold_lat != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_last)
              state <= WAIT_REVERT;
          end
        end
        WAIT_REVERT: begin
          if (quiet_done) begin
            select_line  <= DEFAULT_SEL;
            switch_pulse <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_mux_ctrl.sv
// Directed-vector bench for output_mux_ctrl with hand-computed expectations
// (WIDTH=4, IDLE_CYCLES=8, HOLD_WIDTH=16, DEFAULT_SEL=0).
module tb_output_mux_ctrl;

  logic        sys_clk;
  logic        n_reset;
  logic [3:0]  bus_line;
  logic [3:0]  req_sel;
  logic [15:0] req_hold;
  logic        req_valid;
  logic        req_ready;
  logic        abort;
  logic [3:0]  select_line;
  logic        switch_pulse;
  logic        busy;

  int n_vec;
  int n_err;
  int pulse_cnt;
  int p0;

  output_mux_ctrl #(
    .WIDTH       (4),
    .IDLE_CYCLES (8),
    .HOLD_WIDTH  (16),
    .DEFAULT_SEL (4'b0000)
  ) dut (
    .sys_clk      (sys_clk),
    .n_reset      (n_reset),
    .bus_line     (bus_line),
    .req_sel      (req_sel),
    .req_hold     (req_hold),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .abort        (abort),
    .select_line  (select_line),
    .switch_pulse (switch_pulse),
    .busy         (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // switch_pulse is high for exactly one full period, so one negedge per pulse.
  always @(negedge sys_clk) if (switch_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic hold_ticks(input int n, input logic [3:0] sel, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, 32'(select_line), 32'(sel));
      chk({tag, "_pulse"}, 32'(switch_pulse), 0);
    end
  endtask

  task automatic send(input logic [3:0] sel, input logic [15:0] hold);
    req_sel   = sel;
    req_hold  = hold;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; pulse_cnt = 0;
    n_reset = 1'b0; bus_line = '0; req_sel = '0; req_hold = '0;
    req_valid = 1'b0; abort = 1'b0;

    // reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_sel", 32'(select_line), 0);
    chk("rst_pulse", 32'(switch_pulse), 0);
    chk("rst_busy", 32'(busy), 0);
    n_reset = 1'b1;
    tick();
    chk("rst_ready", 32'(req_ready), 1);

    // quiet bus, mask 1010 for 5 cycles
    p0 = pulse_cnt;
    send(4'b1010, 16'd5);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(req_ready), 0);
    hold_ticks(7, 4'b0000, "t1_wait");
    tick();
    chk("t1_apply", 32'(select_line), 32'(4'b1010));
    chk("t1_apply_pulse", 32'(switch_pulse), 1);
    hold_ticks(12, 4'b1010, "t1_active");
    tick();
    chk("t1_revert", 32'(select_line), 0);
    chk("t1_revert_pulse", 32'(switch_pulse), 1);
    chk("t1_revert_busy", 32'(busy), 0);
    tick();
    chk("t1_pulses", 32'(pulse_cnt - p0), 2);

    // bus toggling every 3 cycles stalls the apply
    send(4'b0101, 16'd2);
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) bus_line[0] = ~bus_line[0];
      tick();
      chk("t2_stall", 32'(select_line), 0);
      chk("t2_stall_pulse", 32'(switch_pulse), 0);
    end
    hold_ticks(5, 4'b0000, "t2_quiet");
    tick();
    chk("t2_apply", 32'(select_line), 32'(4'b0101));
    chk("t2_apply_pulse", 32'(switch_pulse), 1);
    hold_ticks(9, 4'b0101, "t2_active");
    tick();
    chk("t2_revert", 32'(select_line), 0);
    chk("t2_revert_busy", 32'(busy), 0);

    // persistent mask until abort
    send(4'b1111, 16'd0);
    hold_ticks(7, 4'b0000, "t3_wait");
    tick();
    chk("t3_apply", 32'(select_line), 32'(4'b1111));
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("t3_persist", 32'(select_line), 32'(4'b1111));
    end
    chk("t3_persist_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    hold_ticks(7, 4'b1111, "t3_revwait");
    chk("t3_revwait_busy", 32'(busy), 1);
    tick();
    chk("t3_revert", 32'(select_line), 0);
    chk("t3_revert_pulse", 32'(switch_pulse), 1);
    chk("t3_revert_busy", 32'(busy), 0);

    // abort during WAIT_APPLY
    tick();
    p0 = pulse_cnt;
    send(4'b0011, 16'd4);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ready", 32'(req_ready), 1);
    hold_ticks(10, 4'b0000, "t4_idle");
    chk("t4_pulses", 32'(pulse_cnt - p0), 0);

    // request held during ACTIVE is not taken until IDLE
    send(4'b0110, 16'd3);
    hold_ticks(7, 4'b0000, "t5_wait");
    tick();
    chk("t5_apply", 32'(select_line), 32'(4'b0110));
    req_sel = 4'b1001; req_hold = 16'd1; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_ready_low", 32'(req_ready), 0);
      chk("t5_sel_kept", 32'(select_line), 32'(4'b0110));
    end
    tick();
    chk("t5_revert", 32'(select_line), 0);
    chk("t5_ready_back", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    chk("t5_accept", 32'(busy), 1);
    hold_ticks(7, 4'b0000, "t5_wait2");
    tick();
    chk("t5_apply2", 32'(select_line), 32'(4'b1001));
    hold_ticks(8, 4'b1001, "t5_active2");
    tick();
    chk("t5_revert2", 32'(select_line), 0);
    chk("t5_revert2_busy", 32'(busy), 0);

    // async reset during ACTIVE
    send(4'b0110, 16'd0);
    hold_ticks(7, 4'b0000, "t6_wait");
    tick();
    chk("t6_apply", 32'(select_line), 32'(4'b0110));
    tick(); tick();
    #2 n_reset = 1'b0;
    #1;
    chk("t6_rst_sel", 32'(select_line), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    n_reset = 1'b1;
    tick();
    chk("t6_rst_sel_hold", 32'(select_line), 0);
    send(4'b1100, 16'd1);
    hold_ticks(7, 4'b0000, "t6_wait2");
    tick();
    chk("t6_apply2", 32'(select_line), 32'(4'b1100));
    hold_ticks(8, 4'b1100, "t6_active2");
    tick();
    chk("t6_revert2", 32'(select_line), 0);

    // same-mask apply still pulses; abort with request in IDLE is ignored,
    // abort in WAIT_REVERT is ignored
    tick();
    p0 = pulse_cnt;
    req_sel = 4'b0000; req_hold = 16'd1; req_valid = 1'b1; abort = 1'b1;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    chk("t7_accept", 32'(busy), 1);
    hold_ticks(7, 4'b0000, "t7_wait");
    tick();
    chk("t7_apply_pulse", 32'(switch_pulse), 1);
    hold_ticks(2, 4'b0000, "t7_rev_a");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t7_abort_ign", 32'(busy), 1);
    hold_ticks(5, 4'b0000, "t7_rev_b");
    tick();
    chk("t7_revert_pulse", 32'(switch_pulse), 1);
    chk("t7_revert_busy", 32'(busy), 0);
    tick();
    chk("t7_pulses", 32'(pulse_cnt - p0), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
